// File: rtl/id_stage_p_pkg.sv
// id_pkg: instruction field encodings and ALU control values shared by
// the decode stage (id_stage_p) and its operand multiplexers.
package id_pkg;

    // Primary opcodes handled by this stage
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;

    // SPECIAL funct codes handled by this stage
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    // Result class selected in execute
    typedef enum logic [2:0] {
        RES_NOP   = 3'd0,
        RES_LOGIC = 3'd1,
        RES_SHIFT = 3'd2
    } alusel_e;

    // Operation code handed to execute
    typedef enum logic [7:0] {
        OP_NOP = 8'h00,
        OP_SRL = 8'h02,
        OP_SRA = 8'h03,
        OP_AND = 8'h24,
        OP_OR  = 8'h25,
        OP_XOR = 8'h26,
        OP_NOR = 8'h27,
        OP_SLL = 8'h7C
    } aluop_e;

    // Destination used by instructions that do not write the regfile
    localparam int NOP_REG_ADDR = 0;

endpackage

// File: rtl/id_stage_p_operand_mux.sv
// id_operand_mux: picks one source operand from the immediate, the
// regfile or the forwarding sources, and reports which sources match.
// Bypassing exists only when ID_FWD_EN is defined; otherwise the
// forwarded data is ignored and only the match flags are produced.
module id_operand_mux
    import id_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                       read_i,
    input  logic [RADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]          imm_i,
    input  logic [DATA_W-1:0]          reg_data_i,
    input  logic [NUM_FWD-1:0]         fwd_wreg_i,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata_i,
    output logic [DATA_W-1:0]          operand_o,
    output logic [NUM_FWD-1:0]         match_o
);

    // A source matches when it writes the register this operand reads; $0 never matches
    always_comb begin
        match_o = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            match_o[k] = read_i && (addr_i != '0) && fwd_wreg_i[k] &&
                         (fwd_waddr_i[k*RADDR_W +: RADDR_W] == addr_i);
        end
    end

    // Operand select: immediate, hard zero for $0, youngest matching source, else regfile
    always_comb begin
        operand_o = reg_data_i;
        if (!read_i) begin
            operand_o = imm_i;
        end else if (addr_i == '0) begin
            operand_o = '0;
        end
`ifdef ID_FWD_EN
        else begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (match_o[k]) operand_o = fwd_wdata_i[k*DATA_W +: DATA_W];
            end
        end
`endif
    end

`ifndef ID_FWD_EN
    logic unused_wdata;
    assign unused_wdata = ^fwd_wdata_i;
`endif

endmodule

// File: rtl/id_stage_p.sv
// id_stage_p: decode stage with built-in ID/EX register. Decodes the
// logical, shift and LUI instructions, resolves operands, stalls on
// hazards and hands results to execute over a valid/ready handshake.
// Optional feature macro: ID_FWD_EN (operand bypassing from fwd_* sources).
module id_stage_p
    import id_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          pc_i,
    input  logic [31:0]                inst_i,
    output logic                       reg1_read_o,
    output logic                       reg2_read_o,
    output logic [RADDR_W-1:0]         reg1_addr_o,
    output logic [RADDR_W-1:0]         reg2_addr_o,
    input  logic [DATA_W-1:0]          reg1_data_i,
    input  logic [DATA_W-1:0]          reg2_data_i,
    input  logic [NUM_FWD-1:0]         fwd_wreg_i,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata_i,
    input  logic                       ex_load_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [2:0]                 alusel_o,
    output logic [7:0]                 aluop_o,
    output logic [DATA_W-1:0]          reg1_data_o,
    output logic [DATA_W-1:0]          reg2_data_o,
    output logic [RADDR_W-1:0]         waddr_o,
    output logic                       wreg_o,
    output logic [DATA_W-1:0]          pc_o,
    output logic                       inst_invalid_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [15:0]        imm16;
    logic [4:0]         sa;
    logic [RADDR_W-1:0] rs_addr;
    logic [RADDR_W-1:0] rt_addr;
    logic [RADDR_W-1:0] rd_addr;

    assign opcode  = inst_i[31:26];
    assign funct   = inst_i[5:0];
    assign imm16   = inst_i[15:0];
    assign sa      = inst_i[10:6];
    assign rs_addr = RADDR_W'(inst_i[25:21]);
    assign rt_addr = RADDR_W'(inst_i[20:16]);
    assign rd_addr = RADDR_W'(inst_i[15:11]);

    logic               dec_read1;
    logic               dec_read2;
    logic [DATA_W-1:0]  dec_imm;
    alusel_e            dec_alusel;
    aluop_e             dec_aluop;
    logic [RADDR_W-1:0] dec_waddr;
    logic               dec_wreg;
    logic               dec_invalid;

    // Instruction decode; anything unrecognised becomes a non-writing NOP flagged invalid
    always_comb begin
        dec_read1   = 1'b0;
        dec_read2   = 1'b0;
        dec_imm     = '0;
        dec_alusel  = RES_NOP;
        dec_aluop   = OP_NOP;
        dec_waddr   = RADDR_W'(NOP_REG_ADDR);
        dec_wreg    = 1'b0;
        dec_invalid = 1'b1;
        case (opcode)
            OPC_ORI, OPC_ANDI, OPC_XORI, OPC_LUI: begin
                dec_read1   = 1'b1;
                dec_alusel  = RES_LOGIC;
                dec_waddr   = rt_addr;
                dec_wreg    = 1'b1;
                dec_invalid = 1'b0;
                dec_imm     = DATA_W'(imm16);
                if (opcode == OPC_LUI) dec_imm = DATA_W'({imm16, 16'h0000});
                case (opcode)
                    OPC_ANDI: dec_aluop = OP_AND;
                    OPC_XORI: dec_aluop = OP_XOR;
                    default:  dec_aluop = OP_OR;
                endcase
            end
            OPC_SPECIAL: begin
                case (funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        dec_read1   = 1'b1;
                        dec_read2   = 1'b1;
                        dec_alusel  = RES_LOGIC;
                        dec_waddr   = rd_addr;
                        dec_wreg    = 1'b1;
                        dec_invalid = 1'b0;
                        case (funct)
                            FN_AND:  dec_aluop = OP_AND;
                            FN_OR:   dec_aluop = OP_OR;
                            FN_XOR:  dec_aluop = OP_XOR;
                            default: dec_aluop = OP_NOR;
                        endcase
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec_read2   = 1'b1;
                        dec_imm     = DATA_W'(sa);
                        dec_alusel  = RES_SHIFT;
                        dec_waddr   = rd_addr;
                        dec_wreg    = 1'b1;
                        dec_invalid = 1'b0;
                        case (funct)
                            FN_SLL:  dec_aluop = OP_SLL;
                            FN_SRL:  dec_aluop = OP_SRL;
                            default: dec_aluop = OP_SRA;
                        endcase
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign reg1_read_o = dec_read1;
    assign reg2_read_o = dec_read2;
    assign reg1_addr_o = rs_addr;
    assign reg2_addr_o = rt_addr;

    logic [DATA_W-1:0]  operand1;
    logic [DATA_W-1:0]  operand2;
    logic [NUM_FWD-1:0] match1;
    logic [NUM_FWD-1:0] match2;

    id_operand_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_mux1 (
        .read_i      (dec_read1),
        .addr_i      (rs_addr),
        .imm_i       (dec_imm),
        .reg_data_i  (reg1_data_i),
        .fwd_wreg_i  (fwd_wreg_i),
        .fwd_waddr_i (fwd_waddr_i),
        .fwd_wdata_i (fwd_wdata_i),
        .operand_o   (operand1),
        .match_o     (match1)
    );

    id_operand_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_mux2 (
        .read_i      (dec_read2),
        .addr_i      (rt_addr),
        .imm_i       (dec_imm),
        .reg_data_i  (reg2_data_i),
        .fwd_wreg_i  (fwd_wreg_i),
        .fwd_waddr_i (fwd_waddr_i),
        .fwd_wdata_i (fwd_wdata_i),
        .operand_o   (operand2),
        .match_o     (match2)
    );

    // With bypassing only an in-flight load is a hazard; without it any pending writer is
    logic hazard;
    logic unused_fwd;
`ifdef ID_FWD_EN
    assign hazard     = ex_load_i & (match1[0] | match2[0]);
    assign unused_fwd = ^{match1, match2};
`else
    assign hazard     = |{match1, match2};
    assign unused_fwd = ex_load_i;
`endif

    logic out_valid_q, out_valid_d;
    logic load;

    assign in_ready_o = flush_i | (~hazard & (~out_valid_q | out_ready_i));
    assign load       = in_valid_i & in_ready_o & ~flush_i;

    logic [2:0]         alusel_q, alusel_d;
    logic [7:0]         aluop_q, aluop_d;
    logic [DATA_W-1:0]  reg1_q, reg1_d;
    logic [DATA_W-1:0]  reg2_q, reg2_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic               wreg_q, wreg_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic               invalid_q, invalid_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    // Next state: flush beats load; a consumed output with nothing new behind it drains
    always_comb begin
        out_valid_d = out_valid_q;
        alusel_d    = alusel_q;
        aluop_d     = aluop_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        waddr_d     = waddr_q;
        wreg_d      = wreg_q;
        pc_d        = pc_q;
        invalid_d   = invalid_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            alusel_d    = dec_alusel;
            aluop_d     = dec_aluop;
            reg1_d      = operand1;
            reg2_d      = operand2;
            waddr_d     = dec_waddr;
            wreg_d      = dec_wreg;
            pc_d        = pc_i;
            invalid_d   = dec_invalid;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (in_valid_i && hazard && !flush_i && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // ID/EX register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alusel_q    <= '0;
            aluop_q     <= '0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            waddr_q     <= '0;
            wreg_q      <= 1'b0;
            pc_q        <= '0;
            invalid_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alusel_q    <= alusel_d;
            aluop_q     <= aluop_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            waddr_q     <= waddr_d;
            wreg_q      <= wreg_d;
            pc_q        <= pc_d;
            invalid_q   <= invalid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign alusel_o       = alusel_q;
    assign aluop_o        = aluop_q;
    assign reg1_data_o    = reg1_q;
    assign reg2_data_o    = reg2_q;
    assign waddr_o        = waddr_q;
    assign wreg_o         = wreg_q;
    assign pc_o           = pc_q;
    assign inst_invalid_o = invalid_q;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_p.sv
// tb_id_stage_p: directed scenarios plus a randomized run against a
// behavioural model of the decode stage. Follows ID_FWD_EN like the RTL.
module tb_id_stage_p;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int NUM_FWD = 2;
    localparam int CNT_W   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        reg1_read, reg2_read;
    logic [4:0]  reg1_addr, reg2_addr;
    logic [31:0] reg1_data, reg2_data;
    logic [1:0]  fwd_wreg;
    logic [9:0]  fwd_waddr;
    logic [63:0] fwd_wdata;
    logic        ex_load;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic [31:0] reg1_out, reg2_out;
    logic [4:0]  waddr;
    logic        wreg;
    logic [31:0] pc_out;
    logic        inst_invalid;
    logic [3:0]  stall_cnt;

    logic [31:0] rf [32];
    int tests_run    = 0;
    int tests_failed = 0;

    assign reg1_data = rf[reg1_addr];
    assign reg2_data = rf[reg2_addr];

    id_stage_p #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .pc_i           (pc),
        .inst_i         (inst),
        .reg1_read_o    (reg1_read),
        .reg2_read_o    (reg2_read),
        .reg1_addr_o    (reg1_addr),
        .reg2_addr_o    (reg2_addr),
        .reg1_data_i    (reg1_data),
        .reg2_data_i    (reg2_data),
        .fwd_wreg_i     (fwd_wreg),
        .fwd_waddr_i    (fwd_waddr),
        .fwd_wdata_i    (fwd_wdata),
        .ex_load_i      (ex_load),
        .flush_i        (flush),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .alusel_o       (alusel),
        .aluop_o        (aluop),
        .reg1_data_o    (reg1_out),
        .reg2_data_o    (reg2_out),
        .waddr_o        (waddr),
        .wreg_o         (wreg),
        .pc_o           (pc_out),
        .inst_invalid_o (inst_invalid),
        .stall_cnt_o    (stall_cnt)
    );

    always #5 clk = ~clk;

    wire [118:0] obs = {out_valid, alusel, aluop, reg1_out, reg2_out, waddr, wreg, pc_out, inst_invalid, stall_cnt};

    typedef struct packed {
        logic        rd1;
        logic        rd2;
        logic [31:0] imm;
        logic [2:0]  alusel;
        logic [7:0]  aluop;
        logic [4:0]  waddr;
        logic        wreg;
        logic        invalid;
    } dec_t;

    // Reference decode from the instruction-set rules
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        logic [5:0] op, fn;
        op = i[31:26];
        fn = i[5:0];
        d = '0;
        d.invalid = 1'b1;
        if (op >= 6'h0C && op <= 6'h0F) begin
            d.rd1 = 1'b1; d.alusel = 3'd1; d.waddr = i[20:16]; d.wreg = 1'b1; d.invalid = 1'b0;
            d.imm = (op == 6'h0F) ? {i[15:0], 16'h0} : {16'h0, i[15:0]};
            d.aluop = (op == 6'h0C) ? 8'h24 : (op == 6'h0E) ? 8'h26 : 8'h25;
        end else if (op == 6'h00 && fn >= 6'h24 && fn <= 6'h27) begin
            d.rd1 = 1'b1; d.rd2 = 1'b1; d.alusel = 3'd1; d.aluop = {2'b00, fn};
            d.waddr = i[15:11]; d.wreg = 1'b1; d.invalid = 1'b0;
        end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
            d.rd2 = 1'b1; d.imm = {27'h0, i[10:6]}; d.alusel = 3'd2;
            d.aluop = (fn == 6'h00) ? 8'h7C : {2'b00, fn};
            d.waddr = i[15:11]; d.wreg = 1'b1; d.invalid = 1'b0;
        end
        return d;
    endfunction

    // Reference operand value for one read port
    function automatic logic [31:0] ref_operand(input logic rd, input logic [4:0] a, input logic [31:0] imm,
                                                input logic [31:0] rfv, input logic [1:0] wr,
                                                input logic [9:0] wa, input logic [63:0] wd);
        if (!rd) return imm;
        if (a == 5'd0) return 32'h0;
`ifdef ID_FWD_EN
        for (int k = 0; k < NUM_FWD; k++) begin
            if (wr[k] && wa[k*5 +: 5] == a) return wd[k*32 +: 32];
        end
`endif
        return rfv;
    endfunction

    // Which sources write a nonzero register that the instruction reads
    function automatic logic [1:0] ref_hits(input dec_t d, input logic [31:0] i,
                                            input logic [1:0] wr, input logic [9:0] wa);
        logic [1:0] h;
        for (int k = 0; k < NUM_FWD; k++) begin
            h[k] = wr[k] && ((d.rd1 && i[25:21] != 5'd0 && i[25:21] == wa[k*5 +: 5]) ||
                             (d.rd2 && i[20:16] != 5'd0 && i[20:16] == wa[k*5 +: 5]));
        end
        return h;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs, rt, rd, sa;
        logic [5:0] fn;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 31));
        sa = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
            0: return {6'(6'h0C + $urandom_range(0, 3)), rs, rt, 16'($urandom)};
            1, 2: return {6'h00, rs, rt, rd, sa, 6'(6'h24 + $urandom_range(0, 3))};
            3: begin
                fn = ($urandom_range(0, 2) == 0) ? 6'h00 : 6'(6'h01 + $urandom_range(1, 2));
                return {6'h00, rs, rt, rd, sa, fn};
            end
            4: return 32'($urandom);
            default: return {6'h00, rs, rt, rd, sa, 6'($urandom_range(0, 63))};
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 1'b0; inst = 32'h0; pc = 32'h0;
        fwd_wreg = 2'b00; fwd_waddr = 10'h0; fwd_wdata = 64'h0;
        ex_load = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Load-use setup on AND $5,$4,$6 with source 0 loading $4
    task automatic drive_load_use;
        inst = {6'h00, 5'd4, 5'd6, 5'd5, 5'd0, 6'h24};
        in_valid = 1'b1;
        ex_load = 1'b1;
        fwd_wreg = 2'b01;
        fwd_waddr = {5'd0, 5'd4};
        fwd_wdata = {32'h0, 32'hDEAD_BEEF};
    endtask

    task automatic test_reset;
        do_reset();
        drive_load_use();
        pc = 32'h100;
        tick();
        tick();
        tests_run++;
        if (stall_cnt !== 4'd2) begin
            tests_failed++; $display("[TB] FAIL pre_reset_cnt: got %0d want 2", stall_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (obs !== '0) begin
            tests_failed++; $display("[TB] FAIL reset_state: got %h want 0", obs);
        end
        idle_inputs();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_drop: out_valid got %0b want 0", out_valid);
        end
    endtask

    task automatic test_ori;
        do_reset();
        inst = 32'h3401_1100;
        pc = 32'h400;
        in_valid = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, reg1_read, reg2_read, reg1_addr, reg2_addr} !== {1'b1, 1'b1, 1'b0, 5'd0, 5'd1}) begin
            tests_failed++; $display("[TB] FAIL ori_comb: got %b", {in_ready, reg1_read, reg2_read, reg1_addr, reg2_addr});
        end
        tick();
        tests_run++;
        if ({out_valid, aluop, alusel, reg1_out, reg2_out, waddr, wreg, inst_invalid, pc_out} !==
            {1'b1, 8'h25, 3'd1, 32'h0, 32'h1100, 5'd1, 1'b1, 1'b0, 32'h400}) begin
            tests_failed++;
            $display("[TB] FAIL ori_out: got v=%0b op=%h sel=%0d r1=%h r2=%h wa=%0d wr=%0b inv=%0b pc=%h",
                     out_valid, aluop, alusel, reg1_out, reg2_out, waddr, wreg, inst_invalid, pc_out);
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL ori_drain: out_valid got %0b want 0", out_valid);
        end
    endtask

    task automatic test_fwd_priority;
        do_reset();
        rf[1] = 32'h1111; rf[2] = 32'h2222;
        inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25};
        in_valid = 1'b1;
        fwd_wreg = 2'b11;
        fwd_waddr = {5'd1, 5'd1};
        fwd_wdata = {32'h5555, 32'hAAAA};
`ifdef ID_FWD_EN
        tick();
        tests_run++;
        if ({out_valid, reg1_out, reg2_out, waddr, stall_cnt} !== {1'b1, 32'hAAAA, 32'h2222, 5'd3, 4'd0}) begin
            tests_failed++; $display("[TB] FAIL fwd_priority: got v=%0b r1=%h r2=%h wa=%0d cnt=%0d",
                                     out_valid, reg1_out, reg2_out, waddr, stall_cnt);
        end
`else
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL nofwd_stall: in_ready got %0b want 0", in_ready);
        end
        tick();
        fwd_wreg = 2'b00;
        tick();
        tests_run++;
        if ({out_valid, reg1_out, reg2_out, stall_cnt} !== {1'b1, 32'h1111, 32'h2222, 4'd1}) begin
            tests_failed++; $display("[TB] FAIL nofwd_regfile: got v=%0b r1=%h r2=%h cnt=%0d",
                                     out_valid, reg1_out, reg2_out, stall_cnt);
        end
`endif
    endtask

    task automatic test_load_use;
        do_reset();
        rf[4] = 32'h4444; rf[6] = 32'h6666;
        drive_load_use();
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL lu_ready: got %0b want 0", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, stall_cnt} !== {1'b0, 4'd1}) begin
            tests_failed++; $display("[TB] FAIL lu_bubble: got v=%0b cnt=%0d want v=0 cnt=1", out_valid, stall_cnt);
        end
        ex_load = 1'b0;
        fwd_wreg = 2'b10;
        fwd_waddr = {5'd4, 5'd9};
        fwd_wdata = {32'h1234, 32'h0};
`ifndef ID_FWD_EN
        tick();
        fwd_wreg = 2'b00;
`endif
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL lu_release: in_ready got %0b want 1", in_ready);
        end
        tick();
        tests_run++;
`ifdef ID_FWD_EN
        if ({out_valid, reg1_out, reg2_out, waddr, stall_cnt} !== {1'b1, 32'h1234, 32'h6666, 5'd5, 4'd1}) begin
`else
        if ({out_valid, reg1_out, reg2_out, waddr, stall_cnt} !== {1'b1, 32'h4444, 32'h6666, 5'd5, 4'd2}) begin
`endif
            tests_failed++; $display("[TB] FAIL lu_issue: got v=%0b r1=%h r2=%h wa=%0d cnt=%0d",
                                     out_valid, reg1_out, reg2_out, waddr, stall_cnt);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        inst = {6'h0D, 5'd0, 5'd7, 16'h00FF};
        in_valid = 1'b1;
        tick();
        inst = {6'h0E, 5'd0, 5'd8, 16'h0F0F};
        out_ready = 1'b0;
        repeat (3) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++; $display("[TB] FAIL bp_ready: got %0b want 0", in_ready);
            end
            tick();
            tests_run++;
            if ({out_valid, aluop, reg2_out, waddr} !== {1'b1, 8'h25, 32'h00FF, 5'd7}) begin
                tests_failed++; $display("[TB] FAIL bp_hold: got v=%0b op=%h r2=%h wa=%0d", out_valid, aluop, reg2_out, waddr);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL bp_release: got %0b want 1", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, aluop, reg2_out, waddr} !== {1'b1, 8'h26, 32'h0F0F, 5'd8}) begin
            tests_failed++; $display("[TB] FAIL bp_next: got v=%0b op=%h r2=%h wa=%0d", out_valid, aluop, reg2_out, waddr);
        end
    endtask

    task automatic test_flush;
        do_reset();
        inst = {6'h0D, 5'd0, 5'd1, 16'h0001};
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        drive_load_use();
        tick();
        tests_run++;
        if ({out_valid, stall_cnt} !== {1'b1, 4'd1}) begin
            tests_failed++; $display("[TB] FAIL flush_pre: got v=%0b cnt=%0d want v=1 cnt=1", out_valid, stall_cnt);
        end
        flush = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL flush_ready: got %0b want 1", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, stall_cnt} !== {1'b0, 4'd1}) begin
            tests_failed++; $display("[TB] FAIL flush_out: got v=%0b cnt=%0d want v=0 cnt=1", out_valid, stall_cnt);
        end
        idle_inputs();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL flush_drop: out_valid got %0b want 0", out_valid);
        end
    endtask

    task automatic test_invalid_and_shift;
        do_reset();
        rf[3] = 32'h8000_0001;
        inst = {6'h3F, 26'h2A5_A5A5};
        in_valid = 1'b1;
        tick();
        tests_run++;
        if ({out_valid, inst_invalid, wreg, aluop, alusel} !== {1'b1, 1'b1, 1'b0, 8'h00, 3'd0}) begin
            tests_failed++; $display("[TB] FAIL invalid_op: got v=%0b inv=%0b wr=%0b op=%h sel=%0d",
                                     out_valid, inst_invalid, wreg, aluop, alusel);
        end
        inst = {6'h00, 5'd0, 5'd3, 5'd2, 5'd4, 6'h00};
        tick();
        tests_run++;
        if ({out_valid, reg1_out, reg2_out, alusel, aluop, waddr, wreg, inst_invalid} !==
            {1'b1, 32'h4, 32'h8000_0001, 3'd2, 8'h7C, 5'd2, 1'b1, 1'b0}) begin
            tests_failed++; $display("[TB] FAIL sll: got r1=%h r2=%h sel=%0d op=%h wa=%0d wr=%0b inv=%0b",
                                     reg1_out, reg2_out, alusel, aluop, waddr, wreg, inst_invalid);
        end
        inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3E};
        tick();
        tests_run++;
        if ({inst_invalid, wreg, aluop} !== {1'b1, 1'b0, 8'h00}) begin
            tests_failed++; $display("[TB] FAIL invalid_funct: got inv=%0b wr=%0b op=%h", inst_invalid, wreg, aluop);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        drive_load_use();
        repeat (20) tick();
        tests_run++;
        if ({stall_cnt, out_valid} !== {4'hF, 1'b0}) begin
            tests_failed++; $display("[TB] FAIL stall_saturate: got cnt=%0d v=%0b want cnt=15 v=0", stall_cnt, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] imm;
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            imm = 16'(k * 273 + 1);
            inst = {6'h0D, 5'd0, 5'(k + 1), imm};
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++; $display("[TB] FAIL b2b_ready[%0d]: got %0b want 1", k, in_ready);
            end
            tick();
            tests_run++;
            if ({out_valid, reg2_out, waddr} !== {1'b1, {16'h0, imm}, 5'(k + 1)}) begin
                tests_failed++; $display("[TB] FAIL b2b_out[%0d]: got v=%0b r2=%h wa=%0d", k, out_valid, reg2_out, waddr);
            end
        end
    endtask

    task automatic test_random;
        dec_t d;
        logic [1:0]  hits;
        logic        hz, rdy;
        logic        e_valid, e_wreg, e_inv;
        logic [2:0]  e_alusel;
        logic [7:0]  e_aluop;
        logic [31:0] e_r1, e_r2, e_pc;
        logic [4:0]  e_waddr;
        logic [3:0]  e_cnt;
        do_reset();
        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        {e_valid, e_alusel, e_aluop, e_r1, e_r2, e_waddr, e_wreg, e_pc, e_inv, e_cnt} = '0;
        for (int n = 0; n < 400; n++) begin
            inst      = rand_inst();
            pc        = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            ex_load   = ($urandom_range(0, 2) == 0);
            fwd_wreg  = 2'($urandom_range(0, 3));
            fwd_waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_wdata = {32'($urandom), 32'($urandom)};
            #1;
            d = ref_decode(inst);
            hits = ref_hits(d, inst, fwd_wreg, fwd_waddr);
`ifdef ID_FWD_EN
            hz = ex_load && hits[0];
`else
            hz = |hits;
`endif
            rdy = flush || (!hz && (!e_valid || out_ready));
            tests_run++;
            if ({in_ready, reg1_read, reg2_read, reg1_addr, reg2_addr} !==
                {rdy, d.rd1, d.rd2, inst[25:21], inst[20:16]}) begin
                tests_failed++; $display("[TB] FAIL rand_comb[%0d]: got %b want %b", n,
                                         {in_ready, reg1_read, reg2_read, reg1_addr, reg2_addr},
                                         {rdy, d.rd1, d.rd2, inst[25:21], inst[20:16]});
            end
            if (in_valid && hz && !flush && e_cnt != 4'hF) e_cnt = e_cnt + 4'd1;
            if (flush) begin
                e_valid = 1'b0;
            end else if (in_valid && rdy) begin
                e_valid  = 1'b1;
                e_alusel = d.alusel;
                e_aluop  = d.aluop;
                e_r1     = ref_operand(d.rd1, inst[25:21], d.imm, rf[inst[25:21]], fwd_wreg, fwd_waddr, fwd_wdata);
                e_r2     = ref_operand(d.rd2, inst[20:16], d.imm, rf[inst[20:16]], fwd_wreg, fwd_waddr, fwd_wdata);
                e_waddr  = d.waddr;
                e_wreg   = d.wreg;
                e_pc     = pc;
                e_inv    = d.invalid;
            end else if (out_ready) begin
                e_valid = 1'b0;
            end
            tick();
            tests_run++;
            if (obs !== {e_valid, e_alusel, e_aluop, e_r1, e_r2, e_waddr, e_wreg, e_pc, e_inv, e_cnt}) begin
                tests_failed++; $display("[TB] FAIL rand_out[%0d]: got %h want %h", n, obs,
                                         {e_valid, e_alusel, e_aluop, e_r1, e_r2, e_waddr, e_wreg, e_pc, e_inv, e_cnt});
            end
        end
    endtask

    // Scenario sequence
    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'h0;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_ori();
        test_fwd_priority();
        test_load_use();
        test_backpressure();
        test_flush();
        test_invalid_and_shift();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
